// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled start/data/parity/stop recovery into a
// one-entry valid/ready holding register with framing, parity and overrun flags.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RX_TICK,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam int BC_W = $clog2(DATA_BITS + 1);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);
    localparam logic PAR_EN  = (PARITY_EN != 0);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // 1 when the data word plus received parity bit disagree with the selected parity
    function automatic logic parity_fail(input logic [DATA_BITS-1:0] d, input logic pbit);
        return (^d) ^ pbit ^ PAR_ODD;
    endfunction

    state_t                state_q;
    logic                  rx_meta_q;
    logic                  rx_sync_q;
    logic                  tick_q;
    logic                  armed_q;
    logic [OS_W-1:0]       os_cnt_q;
    logic [BC_W-1:0]       bit_cnt_q;
    logic [DATA_BITS-1:0]  shift_q;
    logic                  perr_q;
    logic [DATA_BITS-1:0]  rx_data_q;
    logic                  rx_valid_q;
    logic                  frame_err_q;
    logic                  parity_err_q;
    logic                  overrun_q;
    logic                  busy_q;
    logic                  tick_en_d;

    assign tick_en_d = RX_TICK & ~tick_q;

    // Input conditioning, receive state machine and output holding register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            tick_q       <= 1'b0;
            armed_q      <= 1'b0;
            os_cnt_q     <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            tick_q    <= RX_TICK;
            overrun_q <= 1'b0;
            busy_q    <= (state_q != S_IDLE);
            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
            if (tick_en_d) begin
                case (state_q)
                    // armed only re-sets on a high line, so a held break cannot retrigger
                    S_IDLE: begin
                        if (armed_q && !rx_sync_q) begin
                            state_q  <= S_START;
                            os_cnt_q <= '0;
                            armed_q  <= 1'b0;
                        end else if (rx_sync_q) begin
                            armed_q <= 1'b1;
                        end
                    end
                    S_START: begin
                        if (os_cnt_q == OS_MID) begin
                            os_cnt_q  <= '0;
                            bit_cnt_q <= '0;
                            perr_q    <= 1'b0;
                            state_q   <= rx_sync_q ? S_IDLE : S_DATA;
                        end else begin
                            os_cnt_q <= os_cnt_q + OS_W'(1);
                        end
                    end
                    S_DATA: begin
                        if (os_cnt_q == OS_LAST) begin
                            os_cnt_q  <= '0;
                            shift_q   <= {rx_sync_q, shift_q[DATA_BITS-1:1]};
                            bit_cnt_q <= bit_cnt_q + BC_W'(1);
                            if (bit_cnt_q == BC_LAST) begin
                                state_q <= PAR_EN ? S_PARITY : S_STOP;
                            end
                        end else begin
                            os_cnt_q <= os_cnt_q + OS_W'(1);
                        end
                    end
                    S_PARITY: begin
                        if (os_cnt_q == OS_LAST) begin
                            os_cnt_q <= '0;
                            perr_q   <= parity_fail(shift_q, rx_sync_q);
                            state_q  <= S_STOP;
                        end else begin
                            os_cnt_q <= os_cnt_q + OS_W'(1);
                        end
                    end
                    S_STOP: begin
                        if (os_cnt_q == OS_LAST) begin
                            os_cnt_q <= '0;
                            state_q  <= S_IDLE;
                            if (!rx_valid_q || rx_ready) begin
                                rx_data_q    <= shift_q;
                                frame_err_q  <= ~rx_sync_q;
                                parity_err_q <= PAR_EN & perr_q;
                                rx_valid_q   <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            os_cnt_q <= os_cnt_q + OS_W'(1);
                        end
                    end
                    default: begin
                        state_q  <= S_IDLE;
                        os_cnt_q <= '0;
                    end
                endcase
            end
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule
